// File: rtl/mem_read_pkg.sv
// Shared types and default sizing for the burst read controller and its response buffer.
package mem_read_pkg;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_ADDR_W     = 8;
  localparam int unsigned DEF_LEN_W      = 4;
  localparam int unsigned DEF_TIMEOUT    = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RDY,
    WAIT_LOW
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
    logic                  err;
  } rsp_entry_t;

endpackage

// File: rtl/mem_read_burst_ctrl_if.sv
// Host request/response and level-style memory signals of the burst read controller.
interface mem_read_burst_ctrl_if
  import mem_read_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data_ready;
  logic [DATA_W-1:0] mem_data_bus;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req_valid, req_addr, req_len, mem_data_ready, mem_data_bus, rsp_ready,
    output req_ready, mem_read, mem_addr, rsp_valid, rsp_data, rsp_last, rsp_err, busy
  );

  modport master (
    output req_valid, req_addr, req_len, mem_data_ready, mem_data_bus, rsp_ready,
    input  req_ready, mem_read, mem_addr, rsp_valid, rsp_data, rsp_last, rsp_err, busy
  );

endinterface

// File: rtl/mem_read_fifo.sv
// Synchronous show-ahead FIFO of response beats; push and pop in one cycle are both honoured.
module mem_read_fifo
  import mem_read_pkg::*;
#(
  parameter type         entry_t = rsp_entry_t,
  parameter int unsigned DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t          slots [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  // A pop frees the slot at the edge, so a push alongside it is legal even when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      slots[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_read_burst_ctrl.sv
// Burst read controller: host valid/ready requests drive a level-wait memory read,
// each beat captured once into a response FIFO, with a timeout error beat.
module mem_read_burst_ctrl
  import mem_read_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LEN_W      = DEF_LEN_W,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic                  clk,
  input logic                  rst,
  mem_read_burst_ctrl_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              err;
  } beat_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [TW-1:0]     timer;
  logic              rd_en;
  logic              capture;
  logic              timed_out;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  beat_t             push_entry;
  beat_t             head;

  // Gating the strobe on fifo_full both throttles memory and freezes the timer.
  assign rd_en     = (state == WAIT_RDY) && !fifo_full;
  assign capture   = rd_en && bus.mem_data_ready;
  assign timed_out = rd_en && !bus.mem_data_ready && (timer == TW'(TIMEOUT - 1));
  assign push      = capture || timed_out;

  always_comb begin
    push_entry = '0;
    if (capture) begin
      push_entry.data = bus.mem_data_bus;
      push_entry.last = (remaining == '0);
    end else begin
      push_entry.last = 1'b1;
      push_entry.err  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr      <= bus.req_addr;
            remaining <= bus.req_len;
            timer     <= '0;
            state     <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (capture) begin
            state <= WAIT_LOW;
          end else if (timed_out) begin
            remaining <= '0;
            state     <= IDLE;
          end else if (rd_en) begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_LOW: begin
          // Waiting for the level to drop is what prevents a second capture of the same beat.
          if (!bus.mem_data_ready) begin
            if (remaining == '0) begin
              state <= IDLE;
            end else begin
              addr      <= addr + ADDR_W'(1);
              remaining <= remaining - LEN_W'(1);
              timer     <= '0;
              state     <= WAIT_RDY;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_read_fifo #(
    .entry_t (beat_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (bus.rsp_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.mem_read  = rd_en;
  assign bus.mem_addr  = addr;
  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_data  = fifo_empty ? '0 : head.data;
  assign bus.rsp_last  = !fifo_empty && head.last;
  assign bus.rsp_err   = !fifo_empty && head.err;

endmodule

// File: tb/tb_mem_read_burst_ctrl.sv
// Bench for mem_read_burst_ctrl: behavioural memory responder, host scoreboard,
// directed vector table, hand-written corner sequences and randomized bursts.
module tb_mem_read_burst_ctrl;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       err;
  } rsp_t;

  typedef struct {
    logic [7:0] addr;
    logic [3:0] len;
    int         dly;
    int         hold;
    int         never_at;
    int         exp_n;
    int         exp_mr;
    logic [7:0] exp_first;
    logic [7:0] exp_lastaddr;
    logic [7:0] exp_lastdata;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_read_burst_ctrl_if #(.DATA_W(8), .ADDR_W(8), .LEN_W(4)) bus ();

  mem_read_burst_ctrl #(
    .DATA_W     (8),
    .ADDR_W     (8),
    .LEN_W      (4),
    .TIMEOUT    (TIMEOUT),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] mem_arr [256];
  rsp_t       exp_q[$];
  rsp_t       got_q[$];
  int         beat_q[$];
  int         rdy_pct;
  int         hold_cfg;
  bit         hold_phase;
  bit         loaded;
  bit         seen;
  int         hold_left;
  int         cur_delay;
  int         cnt;
  int         mr_cycles;
  int         caps;
  logic [7:0] exp_addr;
  logic [7:0] first_addr;
  logic [7:0] last_addr;
  vec_t       tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample at the falling edge, then drive host and memory inputs for the next rising edge.
  task automatic step();
    bit   r;
    rsp_t g;
    rsp_t e;
    @(negedge clk);
    bus.req_valid = 1'b0;
    r = (int'($urandom_range(99)) < rdy_pct);
    if (bus.rsp_valid && r) begin
      g = {bus.rsp_data, bus.rsp_last, bus.rsp_err};
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        check("rsp_extra", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("rsp_beat", g, e);
      end
    end
    bus.rsp_ready = r;

    if (hold_phase) begin
      if (hold_left == 0) begin
        bus.mem_data_ready = 1'b0;
        bus.mem_data_bus   = 8'($urandom);
        hold_phase         = 1'b0;
      end else begin
        hold_left--;
      end
    end else if (bus.mem_read) begin
      mr_cycles++;
      if (!seen) begin
        first_addr = bus.mem_addr;
        seen       = 1'b1;
      end
      last_addr = bus.mem_addr;
      if (!loaded) begin
        loaded    = 1'b1;
        cnt       = 0;
        cur_delay = (beat_q.size() > 0) ? beat_q.pop_front() : -1;
        check("mem_addr", bus.mem_addr, exp_addr);
      end
      if (cur_delay >= 0 && cnt >= cur_delay) begin
        bus.mem_data_ready = 1'b1;
        bus.mem_data_bus   = mem_arr[bus.mem_addr];
        hold_phase         = 1'b1;
        hold_left          = (hold_cfg < 0) ? int'($urandom_range(3)) : hold_cfg;
        loaded             = 1'b0;
        exp_addr           = exp_addr + 8'd1;
        caps++;
      end else if (cur_delay >= 0) begin
        cnt++;
      end
    end
  endtask

  // Model: beats read consecutive (wrapping) addresses; a beat that never answers ends the burst with an error beat.
  task automatic issue(input logic [7:0] a, input logic [3:0] l, input int never_at,
                       input int dmin, input int dmax);
    int         n = 0;
    logic [7:0] ai;
    while (!bus.req_ready && n < 500) begin
      step();
      n++;
    end
    check("req_ready_wait", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = l;
    loaded        = 1'b0;
    exp_addr      = a;
    for (int i = 0; i <= int'(l); i++) begin
      ai = a + 8'(i);
      if (i == never_at) begin
        beat_q.push_back(-1);
        exp_q.push_back({8'h00, 1'b1, 1'b1});
        break;
      end
      beat_q.push_back(int'($urandom_range(dmax, dmin)));
      exp_q.push_back({mem_arr[ai], (i == int'(l)), 1'b0});
    end
    step();
  endtask

  task automatic drain();
    int n = 0;
    while (!(exp_q.size() == 0 && bus.req_ready && !bus.rsp_valid && !hold_phase) && n < 3000) begin
      step();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_idle", bus.req_ready, 1);
  endtask

  task automatic clear_stats();
    got_q.delete();
    mr_cycles = 0;
    caps      = 0;
    seen      = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int hi;
    int nl;
    int stale;
    int na;
    logic [7:0] ra;
    logic [3:0] rl;

    for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
    mem_arr[8'h10] = 8'hDE;
    mem_arr[8'hFE] = 8'hA1;
    mem_arr[8'hFF] = 8'hA2;
    mem_arr[8'h00] = 8'hA3;
    mem_arr[8'h01] = 8'hA4;
    mem_arr[8'h8F] = 8'h5C;

    tbl[0] = '{addr: 8'h10, len: 4'd0,  dly: 3, hold: 0, never_at: -1, exp_n: 1,  exp_mr: 4,
               exp_first: 8'h10, exp_lastaddr: 8'h10, exp_lastdata: 8'hDE, exp_err: 1'b0};
    tbl[1] = '{addr: 8'hFE, len: 4'd3,  dly: 0, hold: 0, never_at: -1, exp_n: 4,  exp_mr: 4,
               exp_first: 8'hFE, exp_lastaddr: 8'h01, exp_lastdata: 8'hA4, exp_err: 1'b0};
    tbl[2] = '{addr: 8'h10, len: 4'd0,  dly: 0, hold: 9, never_at: -1, exp_n: 1,  exp_mr: 1,
               exp_first: 8'h10, exp_lastaddr: 8'h10, exp_lastdata: 8'hDE, exp_err: 1'b0};
    tbl[3] = '{addr: 8'h20, len: 4'd2,  dly: 0, hold: 0, never_at: 0,  exp_n: 1,  exp_mr: 16,
               exp_first: 8'h20, exp_lastaddr: 8'h20, exp_lastdata: 8'h00, exp_err: 1'b1};
    tbl[4] = '{addr: 8'h30, len: 4'd3,  dly: 1, hold: 0, never_at: 2,  exp_n: 3,  exp_mr: 20,
               exp_first: 8'h30, exp_lastaddr: 8'h32, exp_lastdata: 8'h00, exp_err: 1'b1};
    tbl[5] = '{addr: 8'h80, len: 4'd15, dly: 0, hold: 0, never_at: -1, exp_n: 16, exp_mr: 16,
               exp_first: 8'h80, exp_lastaddr: 8'h8F, exp_lastdata: 8'h5C, exp_err: 1'b0};

    rst                = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_addr       = '0;
    bus.req_len        = '0;
    bus.mem_data_ready = 1'b0;
    bus.mem_data_bus   = '0;
    bus.rsp_ready      = 1'b0;
    rdy_pct            = 100;
    hold_cfg           = 0;
    hold_phase         = 1'b0;
    loaded             = 1'b0;
    exp_addr           = '0;
    clear_stats();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_mem_read", bus.mem_read, 0);
    check("reset_mem_addr", bus.mem_addr, 0);
    check("reset_rsp_out", {bus.rsp_valid, bus.rsp_last, bus.rsp_err, bus.rsp_data}, 0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      clear_stats();
      rdy_pct  = 100;
      hold_cfg = tbl[v].hold;
      issue(tbl[v].addr, tbl[v].len, tbl[v].never_at, tbl[v].dly, tbl[v].dly);
      drain();
      check($sformatf("v%0d_count", v), got_q.size(), tbl[v].exp_n);
      check($sformatf("v%0d_mem_read_cycles", v), mr_cycles, tbl[v].exp_mr);
      check($sformatf("v%0d_first_addr", v), first_addr, tbl[v].exp_first);
      check($sformatf("v%0d_last_addr", v), last_addr, tbl[v].exp_lastaddr);
      nl = 0;
      foreach (got_q[i]) nl += int'(got_q[i].last);
      check($sformatf("v%0d_last_count", v), nl, 1);
      if (got_q.size() > 0) begin
        check($sformatf("v%0d_final_beat", v), got_q[got_q.size()-1],
              {tbl[v].exp_lastdata, 1'b1, tbl[v].exp_err});
      end else begin
        check($sformatf("v%0d_got_any", v), got_q.size(), tbl[v].exp_n);
      end
    end

    // Latency: strobe in the cycle after acceptance, response visible one cycle later.
    clear_stats();
    rdy_pct  = 100;
    hold_cfg = 0;
    issue(8'h70, 4'd0, -1, 0, 0);
    check("lat_mem_read", bus.mem_read, 1);
    check("lat_busy", bus.busy, 1);
    step();
    check("lat_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_last}, {1'b1, mem_arr[8'h70], 1'b1});
    drain();

    // Timeout: strobe high exactly TIMEOUT cycles, idle again straight after.
    clear_stats();
    issue(8'h50, 4'd0, 0, 0, 0);
    check("to_mem_read_start", bus.mem_read, 1);
    hi = 0;
    n  = 0;
    while (bus.mem_read && n < 100) begin
      hi++;
      step();
      n++;
    end
    check("to_mem_read_high", hi, TIMEOUT);
    check("to_req_ready", bus.req_ready, 1);
    check("to_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_last, bus.rsp_data}, {3'b111, 8'h00});
    drain();

    // Back-pressure: four beats fill the buffer, strobe stays low well past the timeout.
    clear_stats();
    rdy_pct  = 0;
    hold_cfg = 0;
    issue(8'h40, 4'd7, -1, 0, 0);
    repeat (40) step();
    check("bp_captured", caps, 4);
    check("bp_mem_read", bus.mem_read, 0);
    check("bp_busy", bus.busy, 1);
    check("bp_head", {bus.rsp_valid, bus.rsp_data, bus.rsp_err}, {1'b1, mem_arr[8'h40], 1'b0});
    rdy_pct = 100;
    drain();
    check("bp_total", got_q.size(), 8);

    // Reset while the second beat of a burst is outstanding.
    clear_stats();
    rdy_pct  = 0;
    hold_cfg = 0;
    issue(8'h60, 4'd3, -1, 2, 2);
    n = 0;
    while (!(caps == 1 && bus.mem_read) && n < 100) begin
      step();
      n++;
    end
    check("rst_beat2_reached", caps, 1);
    rst = 1'b1;
    step();
    check("rst_mem_read", bus.mem_read, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_last", bus.rsp_last, 0);
    rst                = 1'b0;
    bus.mem_data_ready = 1'b0;
    exp_q.delete();
    beat_q.delete();
    loaded     = 1'b0;
    hold_phase = 1'b0;
    rdy_pct    = 100;
    stale      = 0;
    repeat (12) begin
      step();
      if (bus.rsp_valid || bus.mem_read) stale++;
    end
    check("rst_no_stale", stale, 0);

    // Randomized bursts with random back-pressure, hold times and occasional dead beats.
    clear_stats();
    for (int r = 0; r < 40; r++) begin
      rdy_pct  = int'($urandom_range(100, 20));
      hold_cfg = -1;
      rl       = 4'($urandom_range(15));
      ra       = 8'($urandom);
      na       = ($urandom_range(7) == 0) ? int'($urandom_range(int'(rl))) : -1;
      issue(ra, rl, na, 0, 4);
    end
    rdy_pct = 60;
    drain();
    check("rand_final_rsp_valid", bus.rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
